// File: rtl/ctr_job_if.sv
// Job sequencer bus bundle: plaintext FIFO read side, cipher core launch/return,
// and the ciphertext valid/ready output stream.
interface ctr_job_if #(
    parameter int DATA_W = 128
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_pop;
    logic              core_start;
    logic [DATA_W-1:0] core_key;
    logic [DATA_W-1:0] core_blk;
    logic              core_done;
    logic [DATA_W-1:0] core_ks;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_dest;

    modport master (
        input  fifo_empty, fifo_rdata, core_done, core_ks, out_ready,
        output fifo_pop, core_start, core_key, core_blk, out_valid, out_data, out_dest
    );

    modport slave (
        output fifo_empty, fifo_rdata, core_done, core_ks, out_ready,
        input  fifo_pop, core_start, core_key, core_blk, out_valid, out_data, out_dest
    );
endinterface

// File: rtl/ctr_job_sequencer.sv
// CTR-mode job sequencer: pops plaintext, launches the cipher core on nonce+count,
// and emits plaintext^keystream with its destination on a valid/ready port.
module ctr_job_sequencer #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 8,
    parameter int TO_W   = 6
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              key_wr,
    input  logic              nonce_wr,
    input  logic              dest_wr,
    input  logic [DATA_W-1:0] key_in,
    input  logic [DATA_W-1:0] nonce_in,
    input  logic [DATA_W-1:0] dest_in,
    input  logic              abort,
    input  logic              err_clr,
    ctr_job_if.master         job,
    output logic              busy,
    output logic              cfg_err,
    output logic              ctr_err,
    output logic              to_err
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_EMIT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TO_W-1:0]  TO_MAX  = {TO_W{1'b1}};

    state_t            state_r;
    logic [DATA_W-1:0] key_r, nonce_r, dest_r, pt_r;
    logic              key_v_r, nonce_v_r, dest_v_r;
    logic [CNT_W-1:0]  blk_cnt_r;
    logic              exhausted_r;
    logic [TO_W-1:0]   wdog_r;
    logic              fifo_pop_r, core_start_r, out_valid_r, busy_r;
    logic [DATA_W-1:0] core_key_r, core_blk_r, out_data_r, out_dest_r;
    logic              cfg_err_r, ctr_err_r, to_err_r;

    logic launch_ok_s, cfg_wr_s, done_evt_s, timeout_evt_s, wrap_evt_s;

    assign launch_ok_s   = key_v_r & nonce_v_r & dest_v_r & ~job.fifo_empty & ~exhausted_r & ~abort;
    assign cfg_wr_s      = key_wr | nonce_wr | dest_wr;
    // abort suppresses both core events so an in-flight result is dropped
    assign done_evt_s    = (state_r == ST_WAIT) & job.core_done & ~abort;
    assign timeout_evt_s = (state_r == ST_WAIT) & ~job.core_done & (wdog_r == TO_MAX) & ~abort;
    assign wrap_evt_s    = done_evt_s & (blk_cnt_r == CNT_MAX) & ~nonce_wr;

    // Configuration registers and their written-since-abort flags
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            key_r     <= {DATA_W{1'b0}};
            nonce_r   <= {DATA_W{1'b0}};
            dest_r    <= {DATA_W{1'b0}};
            key_v_r   <= 1'b0;
            nonce_v_r <= 1'b0;
            dest_v_r  <= 1'b0;
        end else begin
            if (key_wr)   key_r   <= key_in;
            if (nonce_wr) nonce_r <= nonce_in;
            if (dest_wr)  dest_r  <= dest_in;
            if (abort) begin
                key_v_r   <= 1'b0;
                nonce_v_r <= 1'b0;
                dest_v_r  <= 1'b0;
            end else begin
                if (key_wr)   key_v_r   <= 1'b1;
                if (nonce_wr) nonce_v_r <= 1'b1;
                if (dest_wr)  dest_v_r  <= 1'b1;
            end
        end
    end

    // Per-nonce block counter; a new nonce restarts the sequence
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            blk_cnt_r   <= {CNT_W{1'b0}};
            exhausted_r <= 1'b0;
        end else if (nonce_wr) begin
            blk_cnt_r   <= {CNT_W{1'b0}};
            exhausted_r <= 1'b0;
        end else if (done_evt_s) begin
            blk_cnt_r <= blk_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (blk_cnt_r == CNT_MAX) exhausted_r <= 1'b1;
        end
    end

    // Sticky error flags; a same-cycle set overrides err_clr
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cfg_err_r <= 1'b0;
            ctr_err_r <= 1'b0;
            to_err_r  <= 1'b0;
        end else begin
            cfg_err_r <= (cfg_wr_s && state_r != ST_IDLE) ? 1'b1 : (err_clr ? 1'b0 : cfg_err_r);
            ctr_err_r <= wrap_evt_s    ? 1'b1 : (err_clr ? 1'b0 : ctr_err_r);
            to_err_r  <= timeout_evt_s ? 1'b1 : (err_clr ? 1'b0 : to_err_r);
        end
    end

    // Job FSM with registered handshake and datapath outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r      <= ST_IDLE;
            pt_r         <= {DATA_W{1'b0}};
            wdog_r       <= {TO_W{1'b0}};
            fifo_pop_r   <= 1'b0;
            core_start_r <= 1'b0;
            core_key_r   <= {DATA_W{1'b0}};
            core_blk_r   <= {DATA_W{1'b0}};
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            out_dest_r   <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
        end else if (abort) begin
            state_r      <= ST_IDLE;
            fifo_pop_r   <= 1'b0;
            core_start_r <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (launch_ok_s) begin
                        state_r    <= ST_POP;
                        fifo_pop_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ST_POP: begin
                    fifo_pop_r   <= 1'b0;
                    pt_r         <= job.fifo_rdata;
                    core_key_r   <= key_r;
                    core_blk_r   <= nonce_r + {{(DATA_W-CNT_W){1'b0}}, blk_cnt_r};
                    out_dest_r   <= dest_r;
                    core_start_r <= 1'b1;
                    state_r      <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    core_start_r <= 1'b0;
                    wdog_r       <= {TO_W{1'b0}};
                    state_r      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (job.core_done) begin
                        out_data_r  <= pt_r ^ job.core_ks;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_EMIT;
                    end else if (wdog_r == TO_MAX) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        wdog_r <= wdog_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_EMIT: begin
                    if (out_valid_r && job.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (launch_ok_s) begin
                            state_r    <= ST_POP;
                            fifo_pop_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    fifo_pop_r   <= 1'b0;
                    core_start_r <= 1'b0;
                    out_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign job.fifo_pop   = fifo_pop_r;
    assign job.core_start = core_start_r;
    assign job.core_key   = core_key_r;
    assign job.core_blk   = core_blk_r;
    assign job.out_valid  = out_valid_r;
    assign job.out_data   = out_data_r;
    assign job.out_dest   = out_dest_r;
    assign busy           = busy_r;
    assign cfg_err        = cfg_err_r;
    assign ctr_err        = ctr_err_r;
    assign to_err         = to_err_r;
endmodule

// File: tb/tb_ctr_job_sequencer.sv
// Randomized bench for ctr_job_sequencer: FIFO/core/sink models plus a job-level
// scoreboard that predicts counter blocks, keys and ciphertext per nonce.
module tb_ctr_job_sequencer;
    localparam int DW = 128;
    localparam int CW = 2;
    localparam int TW = 6;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          key_wr, nonce_wr, dest_wr, abort, err_clr;
    logic [DW-1:0] key_in, nonce_in, dest_in;
    logic          busy, cfg_err, ctr_err, to_err;

    always #5 HCLK = ~HCLK;

    ctr_job_if #(.DATA_W(DW)) job ();

    ctr_job_sequencer #(.DATA_W(DW), .CNT_W(CW), .TO_W(TW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .key_wr(key_wr), .nonce_wr(nonce_wr), .dest_wr(dest_wr),
        .key_in(key_in), .nonce_in(nonce_in), .dest_in(dest_in),
        .abort(abort), .err_clr(err_clr), .job(job.master),
        .busy(busy), .cfg_err(cfg_err), .ctr_err(ctr_err), .to_err(to_err)
    );

    typedef struct {
        logic [DW-1:0] pt;
        logic [DW-1:0] key;
        logic [DW-1:0] blk;
        logic [DW-1:0] dest;
    } job_t;

    job_t          exp_q[$];
    logic [DW-1:0] fifo_q[$];

    logic [DW-1:0] m_key, m_nonce, m_dest;
    bit            m_key_v, m_nonce_v, m_dest_v, m_exh;
    bit            m_cfg_err, m_ctr_err, m_to_err;
    int            m_cnt;

    bit            pop_prev, core_busy, core_hold, hold_valid, rand_ready;
    int            core_left, core_lat, stall_left;
    logic [DW-1:0] ck, cb, h_data, h_dest;
    int            n_pops, n_out, n_starts;
    int            n_checks, n_fail;

    function automatic logic [DW-1:0] ks_fn(input logic [DW-1:0] k, input logic [DW-1:0] b);
        return (k ^ {b[63:0], b[127:64]}) + 128'h9E3779B97F4A7C15F39CC0605CEDC834;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        job.fifo_empty = (fifo_q.size() == 0);
        job.fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push_blocks(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(rnd());
        fifo_refresh();
    endtask

    // One clock: retire last cycle's pop, then observe and react to this cycle's outputs.
    task automatic step();
        job_t e;
        @(posedge HCLK);
        #1;
        if (pop_prev && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            fifo_refresh();
        end
        job.core_done = 1'b0;
        if (job.fifo_pop) begin
            n_pops++;
            check_val("pop_allowed",
                      DW'((fifo_q.size() > 0) && m_key_v && m_nonce_v && m_dest_v && !m_exh), DW'(1));
            if (fifo_q.size() > 0) begin
                e.pt = fifo_q[0]; e.key = m_key; e.blk = m_nonce + DW'(m_cnt); e.dest = m_dest;
                exp_q.push_back(e);
            end
        end
        pop_prev = job.fifo_pop;
        if (job.core_start) begin
            n_starts++;
            check_val("start_one_job", DW'(exp_q.size() == 1 && !core_busy), DW'(1));
            if (exp_q.size() > 0) begin
                check_val("core_blk", job.core_blk, exp_q[0].blk);
                check_val("core_key", job.core_key, exp_q[0].key);
            end
            core_busy = 1'b1; core_left = core_lat; ck = job.core_key; cb = job.core_blk;
        end else if (core_busy) begin
            check_val("core_key_hold", job.core_key, ck);
            if (!core_hold) begin
                core_left--;
                if (core_left == 0) begin
                    job.core_done = 1'b1;
                    job.core_ks   = ks_fn(ck, cb);
                    core_busy     = 1'b0;
                    m_cnt         = (m_cnt + 1) % (1 << CW);
                    if (m_cnt == 0) begin m_exh = 1'b1; m_ctr_err = 1'b1; end
                end
            end
        end
        if (stall_left > 0 && job.out_valid) begin
            job.out_ready = 1'b0;
            stall_left--;
        end else begin
            job.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (job.out_valid) begin
            if (hold_valid) begin
                check_val("out_data_stable", job.out_data, h_data);
                check_val("out_dest_stable", job.out_dest, h_dest);
            end
            if (job.out_ready) begin
                n_out++;
                hold_valid = 1'b0;
                check_val("out_expected", DW'(exp_q.size()), DW'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_val("out_data", job.out_data, e.pt ^ ks_fn(e.key, e.blk));
                    check_val("out_dest", job.out_dest, e.dest);
                end
            end else begin
                hold_valid = 1'b1; h_data = job.out_data; h_dest = job.out_dest;
            end
        end else begin
            hold_valid = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_quiet(input int bound);
        int k = 0;
        while (k < bound && !(exp_q.size() == 0 && !busy &&
               (fifo_q.size() == 0 || m_exh || !(m_key_v && m_nonce_v && m_dest_v)))) begin
            step();
            k++;
        end
        check_val("quiet_in_budget", DW'(k < bound), DW'(1));
    endtask

    task automatic wr_cfg(input int which, input logic [DW-1:0] v);
        case (which)
            0: begin key_wr = 1'b1; key_in = v; m_key = v; m_key_v = 1'b1; end
            1: begin nonce_wr = 1'b1; nonce_in = v; m_nonce = v; m_nonce_v = 1'b1; m_cnt = 0; m_exh = 1'b0; end
            default: begin dest_wr = 1'b1; dest_in = v; m_dest = v; m_dest_v = 1'b1; end
        endcase
        step();
        key_wr = 1'b0; nonce_wr = 1'b0; dest_wr = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        m_cfg_err = 1'b0; m_ctr_err = 1'b0; m_to_err = 1'b0;
        step();
        err_clr = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        m_key_v = 1'b0; m_nonce_v = 1'b0; m_dest_v = 1'b0;
        exp_q.delete(); core_busy = 1'b0; hold_valid = 1'b0;
        step();
        abort = 1'b0;
    endtask

    task automatic wait_start(input int bound);
        int s0 = n_starts;
        for (int i = 0; i < bound && n_starts == s0; i++) step();
        check_val("start_seen", DW'(n_starts != s0), DW'(1));
    endtask

    task automatic check_errs(input string tag);
        check_val({tag, "_cfg_err"}, DW'(cfg_err), DW'(m_cfg_err));
        check_val({tag, "_ctr_err"}, DW'(ctr_err), DW'(m_ctr_err));
        check_val({tag, "_to_err"},  DW'(to_err),  DW'(m_to_err));
    endtask

    initial begin
        int p0, o0;
        logic [DW-1:0] all_ones;
        key_wr = 1'b0; nonce_wr = 1'b0; dest_wr = 1'b0; abort = 1'b0; err_clr = 1'b0;
        key_in = '0; nonce_in = '0; dest_in = '0;
        job.out_ready = 1'b0; job.core_done = 1'b0; job.core_ks = '0;
        fifo_refresh();
        core_lat = 4; rand_ready = 1'b0; stall_left = 0; core_hold = 1'b0;
        HRESETn = 1'b0;
        #23;
        check_val("rst_busy", DW'(busy), DW'(0));
        check_val("rst_fifo_pop", DW'(job.fifo_pop), DW'(0));
        check_val("rst_core_start", DW'(job.core_start), DW'(0));
        check_val("rst_out_valid", DW'(job.out_valid), DW'(0));
        check_val("rst_core_key", job.core_key, '0);
        check_val("rst_core_blk", job.core_blk, '0);
        check_val("rst_out_data", job.out_data, '0);
        check_val("rst_out_dest", job.out_dest, '0);
        check_errs("rst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();

        // Single block on nonce ..FE, then a second block proves the count advanced to 1
        wr_cfg(0, rnd()); wr_cfg(1, 128'h0000_0000_0000_0000_0000_0000_0000_00FE); wr_cfg(2, rnd());
        push_blocks(1);
        run_until_quiet(200);
        check_val("t1_outputs", DW'(n_out), DW'(1));
        check_val("t1_pops", DW'(n_pops), DW'(1));
        push_blocks(1);
        run_until_quiet(200);
        check_val("t1_second_out", DW'(n_out), DW'(2));

        // Three blocks with a 5-cycle stall on the first output
        wr_cfg(1, rnd());
        p0 = n_pops; o0 = n_out; stall_left = 5;
        push_blocks(3);
        run_until_quiet(300);
        check_val("t2_pops", DW'(n_pops - p0), DW'(3));
        check_val("t2_outs", DW'(n_out - o0), DW'(3));

        // Counter exhaustion across the 2**DATA_W nonce wrap, then recovery with a new nonce
        all_ones = '1;
        wr_cfg(1, all_ones);
        o0 = n_out;
        push_blocks(5);
        run_until_quiet(400);
        check_val("t3_outs", DW'(n_out - o0), DW'(4));
        check_val("t3_left", DW'(fifo_q.size()), DW'(1));
        check_errs("t3");
        wr_cfg(1, rnd());
        run_until_quiet(200);
        check_val("t3_fifth_out", DW'(n_out - o0), DW'(5));
        check_val("t3_drained", DW'(fifo_q.size()), DW'(0));
        check_errs("t3b");
        clear_errors();
        check_errs("t3_clr");

        // Key rewritten while the core is working
        core_lat = 8; rand_ready = 1'b1;
        push_blocks(2);
        wait_start(40);
        run(2);
        m_cfg_err = 1'b1;
        wr_cfg(0, rnd());
        run_until_quiet(300);
        check_errs("t4");
        clear_errors();
        check_errs("t4_clr");

        // Core never answers: watchdog expiry
        core_hold = 1'b1;
        push_blocks(1);
        wait_start(40);
        run(50);
        check_val("t5_busy_waiting", DW'(busy), DW'(1));
        check_val("t5_no_to_yet", DW'(to_err), DW'(0));
        run(20);
        m_to_err = 1'b1;
        check_val("t5_idle", DW'(busy), DW'(0));
        check_errs("t5");
        check_val("t5_block_gone", DW'(fifo_q.size()), DW'(0));
        core_hold = 1'b0; core_busy = 1'b0; exp_q.delete();
        clear_errors();
        check_errs("t5_clr");

        // Abort while an output is stalled
        core_lat = 2; stall_left = 1000;
        p0 = n_pops;
        push_blocks(3);
        for (int i = 0; i < 60 && !job.out_valid; i++) step();
        check_val("t6_valid_seen", DW'(job.out_valid), DW'(1));
        do_abort();
        check_val("t6_valid_drop", DW'(job.out_valid), DW'(0));
        check_val("t6_busy", DW'(busy), DW'(0));
        run(10);
        check_val("t6_pops", DW'(n_pops - p0), DW'(1));
        check_val("t6_left", DW'(fifo_q.size()), DW'(2));
        stall_left = 0;
        wr_cfg(0, rnd()); wr_cfg(1, rnd()); wr_cfg(2, rnd());
        run_until_quiet(300);
        check_val("t6_drained", DW'(fifo_q.size()), DW'(0));

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            core_lat = $urandom_range(1, 6);
            wr_cfg(0, rnd());
            wr_cfg(1, (r == 3) ? (all_ones - DW'(1)) : rnd());
            wr_cfg(2, rnd());
            push_blocks($urandom_range(1, 6));
            run_until_quiet(600);
            if (m_exh && fifo_q.size() > 0) begin
                wr_cfg(1, rnd());
                run_until_quiet(600);
            end
            check_val("rnd_drained", DW'(fifo_q.size()), DW'(0));
            check_errs("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
